// File: rtl/ddr3_mem_sched.sv
// Open-page DDR3 command scheduler: one 4-byte CPU request at a time,
// PRE/ACT/RD/WR sequencing with tRP/tRCD gaps and 4-beat wrapped bursts.
module ddr3_mem_sched #(
  parameter int T_RP  = 7,
  parameter int T_RCD = 7,
  parameter int ROW_W = 15,
  parameter int COL_W = 7
) (
  input  logic                   cpu_clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ROW_W+COL_W-1:0] cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [31:0]            cpu_rdata,
  output logic                   CK,
  output logic                   CK_N,
  output logic                   CS_N,
  output logic                   RAS_N,
  output logic                   CAS_N,
  output logic                   WE_N,
  output logic [ROW_W-1:0]       ADDR,
  output logic [COL_W-1:0]       COL,
  output logic [7:0]             WR_DATA,
  input  logic [7:0]             RD_DATA,
  input  logic                   DQS_N
);

  localparam int CNT_W = $clog2((T_RP > T_RCD) ? T_RP : T_RCD) + 1;
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 2);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_RST = 4'b1111;

  typedef enum logic [3:0] {
    INIT_PRE, INIT_WAIT, IDLE, PRE_CMD, PRE_WAIT, ACT_CMD,
    ACT_WAIT, ISSUE, WBURST, RBURST, DONE
  } state_e;

  state_e             state_q, state_d;
  logic               live_q, live_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [1:0]         beat_q, beat_d;
  logic               we_q, we_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [23:0]        rbuf_q, rbuf_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic               row_open_q, row_open_d;
  logic [ROW_W-1:0]   req_row;
  logic [3:0]         cmd;

  assign req_row = cpu_addr[ROW_W+COL_W-1:COL_W];

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT_PRE;
      live_q     <= 1'b0;
      wait_q     <= '0;
      beat_q     <= '0;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      open_row_q <= '0;
      row_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      wait_q     <= wait_d;
      beat_q     <= beat_d;
      we_q       <= we_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      open_row_q <= open_row_d;
      row_open_q <= row_open_d;
    end
  end

  // live_q holds INIT_PRE for one extra edge so the PRE is visible after reset release.
  always_comb begin
    state_d    = state_q;
    live_d     = 1'b1;
    wait_d     = wait_q;
    beat_d     = beat_q;
    we_d       = we_q;
    row_d      = row_q;
    col_d      = col_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    open_row_d = open_row_q;
    row_open_d = row_open_q;
    case (state_q)
      INIT_PRE: begin
        if (live_q) begin
          state_d = INIT_WAIT;
          wait_d  = RP_LOAD;
        end
      end
      INIT_WAIT: begin
        if (wait_q == '0) state_d = IDLE;
        else              wait_d  = wait_q - 1'b1;
      end
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          row_d   = req_row;
          col_d   = cpu_addr[COL_W-1:0];
          wdata_d = cpu_wdata;
          beat_d  = '0;
          if (row_open_q && (req_row == open_row_q)) begin
            state_d = ISSUE;
          end else if (row_open_q) begin
            state_d = PRE_CMD;
          end else begin
            state_d    = ACT_CMD;
            open_row_d = req_row;
            row_open_d = 1'b1;
          end
        end
      end
      PRE_CMD: begin
        row_open_d = 1'b0;
        state_d    = PRE_WAIT;
        wait_d     = RP_LOAD;
      end
      PRE_WAIT: begin
        if (wait_q == '0) begin
          state_d    = ACT_CMD;
          open_row_d = row_q;
          row_open_d = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ACT_CMD: begin
        state_d = ACT_WAIT;
        wait_d  = RCD_LOAD;
      end
      ACT_WAIT: begin
        if (wait_q == '0) state_d = ISSUE;
        else              wait_d  = wait_q - 1'b1;
      end
      ISSUE: state_d = we_q ? WBURST : RBURST;
      WBURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DONE;
      end
      RBURST: begin
        // The final beat goes straight into cpu_rdata so it changes only on completion.
        if (!DQS_N) begin
          beat_d = beat_q + 2'd1;
          case (beat_q)
            2'd0:    rbuf_d[7:0]   = RD_DATA;
            2'd1:    rbuf_d[15:8]  = RD_DATA;
            2'd2:    rbuf_d[23:16] = RD_DATA;
            default: begin
              rdata_d = {RD_DATA, rbuf_q};
              state_d = DONE;
            end
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = INIT_PRE;
    endcase
  end

  always_comb begin
    cmd = CMD_NOP;
    case (state_q)
      INIT_PRE, PRE_CMD: cmd = CMD_PRE;
      ACT_CMD:           cmd = CMD_ACT;
      ISSUE:             cmd = we_q ? CMD_WR : CMD_RD;
      default:           cmd = CMD_NOP;
    endcase
    if (!live_q) cmd = CMD_RST;
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd;
  assign CK        = cpu_clk;
  assign CK_N      = ~cpu_clk;
  assign ADDR      = open_row_q;
  assign COL       = {col_q[COL_W-1:2], col_q[1:0] + beat_q};
  assign WR_DATA   = (state_q == WBURST) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
  assign cpu_ready = (state_q == IDLE);
  assign cpu_done  = (state_q == DONE);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_ddr3_mem_sched.sv
// Bench for ddr3_mem_sched: a behavioural DDR3 device, a table of CPU requests
// with expected command timing, and a done-time scoreboard for cpu_rdata.
module tb_ddr3_mem_sched;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic        CK, CK_N, CS_N, RAS_N, CAS_N, WE_N;
  logic [14:0] ADDR;
  logic [6:0]  COL;
  logic [7:0]  WR_DATA;
  logic [7:0]  RD_DATA = 8'h00;
  logic        DQS_N = 1'b1;
  logic [3:0]  cmd;

  ddr3_mem_sched #(.T_RP(7), .T_RCD(7), .ROW_W(15), .COL_W(7)) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .CK(CK), .CK_N(CK_N),
    .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .ADDR(ADDR),
    .COL(COL), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .DQS_N(DQS_N)
  );

  assign cmd = {CS_N, RAS_N, CAS_N, WE_N};

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [14:0] row;
    logic [6:0]  col;
    logic [31:0] wdata;
    int          expPre;
    int          expAct;
    int          expCmd;
    int          expLat;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    logic        isRead;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];
  sb_t  sbEntry;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Device model: latches the row on ACT, streams 4 wrapped beats after RD/WR.
  logic [7:0]  devMem [int];
  logic [14:0] devRow = '0;
  logic [6:0]  devCol = '0;
  logic [1:0]  devBeat = '0;
  int          rdLeft = 0;
  int          wrLeft = 0;

  function automatic int devKey(input logic [14:0] r, input logic [6:0] c, input logic [1:0] k);
    logic [1:0] lo;
    lo = c[1:0] + k;
    return int'({r, c[6:2], lo});
  endfunction

  always @(negedge cpu_clk) begin
    if (rdLeft > 0) begin
      DQS_N   = 1'b0;
      RD_DATA = devMem.exists(devKey(devRow, devCol, devBeat)) ?
                devMem[devKey(devRow, devCol, devBeat)] : 8'h00;
      devBeat = devBeat + 2'd1;
      rdLeft--;
    end else begin
      DQS_N   = 1'b1;
      RD_DATA = 8'h00;
    end
    if (wrLeft > 0) begin
      devMem[devKey(devRow, devCol, devBeat)] = WR_DATA;
      devBeat = devBeat + 2'd1;
      wrLeft--;
    end
    if (!reset_n) begin
      rdLeft = 0;
      wrLeft = 0;
    end else if (cmd == ACT) begin
      devRow = ADDR;
    end else if (cmd == RD || cmd == WR) begin
      devCol  = COL;
      devBeat = 2'd0;
      if (cmd == RD) rdLeft = 4;
      else           wrLeft = 4;
    end
  end

  // Scoreboard: each completion pops the entry pushed when its request was driven.
  always @(negedge cpu_clk) begin
    if (reset_n && cpu_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got cpu_done=1, expected no completion");
      end else begin
        sbEntry = sbq.pop_front();
        checkOutput(sbEntry.isRead ? "sb_rdata" : "sb_rdata_hold", cpu_rdata, sbEntry.rdata);
      end
    end
  end

  task automatic waitReady(output logic ok);
    int cnt = 0;
    @(negedge cpu_clk);
    while (!cpu_ready && cnt < 60) begin
      @(negedge cpu_clk);
      cnt++;
    end
    ok = cpu_ready;
    checkOutput("ready_before_req", 32'(cpu_ready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic        ok;
    int          preC = 0, actC = 0, cmdC = 0, doneC = 0;
    logic [3:0]  cmdCode = 4'hF;
    logic [14:0] actAddr = '0, cmdAddr = '0;
    logic [6:0]  cmdCol = '0, expCol;
    logic [1:0]  lo;
    int          k;
    waitReady(ok);
    if (!ok) return;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = {v.row, v.col};
    cpu_wdata = v.wdata;
    sbq.push_back('{isRead: !v.we, rdata: v.expRdata});
    for (int n = 1; n <= 40 && doneC == 0; n++) begin
      @(negedge cpu_clk);
      if (n == 1) cpu_req = 1'b0;
      if (cmd == PRE && preC == 0) preC = n;
      if (cmd == ACT && actC == 0) begin
        actC    = n;
        actAddr = ADDR;
      end
      if ((cmd == RD || cmd == WR) && cmdC == 0) begin
        cmdC    = n;
        cmdCode = cmd;
        cmdAddr = ADDR;
        cmdCol  = COL;
        checkOutput($sformatf("v%0d wr_data_idle", idx), 32'(WR_DATA), 32'h0);
      end
      if (v.we && cmdC != 0 && n > cmdC && n <= cmdC + 4) begin
        k      = n - cmdC - 1;
        lo     = v.col[1:0] + 2'(k);
        expCol = {v.col[6:2], lo};
        checkOutput($sformatf("v%0d beat%0d col", idx, k), 32'(COL), 32'(expCol));
        checkOutput($sformatf("v%0d beat%0d data", idx, k), 32'(WR_DATA), 32'(v.wdata[k*8 +: 8]));
      end
      if (cpu_done) doneC = n;
    end
    checkOutput($sformatf("v%0d pre_cycle", idx), 32'(preC), 32'(v.expPre));
    checkOutput($sformatf("v%0d act_cycle", idx), 32'(actC), 32'(v.expAct));
    if (v.expAct != 0)
      checkOutput($sformatf("v%0d act_addr", idx), 32'(actAddr), 32'(v.row));
    checkOutput($sformatf("v%0d cmd_cycle", idx), 32'(cmdC), 32'(v.expCmd));
    checkOutput($sformatf("v%0d cmd_code", idx), 32'(cmdCode), 32'(v.we ? WR : RD));
    checkOutput($sformatf("v%0d cmd_addr", idx), 32'(cmdAddr), 32'(v.row));
    checkOutput($sformatf("v%0d cmd_col", idx), 32'(cmdCol), 32'(v.col));
    checkOutput($sformatf("v%0d latency", idx), 32'(doneC), 32'(v.expLat));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " cmd"}, 32'(cmd), 32'hF);
    checkOutput({tag, " addr"}, 32'(ADDR), 32'h0);
    checkOutput({tag, " col"}, 32'(COL), 32'h0);
    checkOutput({tag, " wr_data"}, 32'(WR_DATA), 32'h0);
    checkOutput({tag, " ready"}, 32'(cpu_ready), 32'h0);
    checkOutput({tag, " done"}, 32'(cpu_done), 32'h0);
    checkOutput({tag, " rdata"}, cpu_rdata, 32'h0);
  endtask

  task automatic releaseAndCheckInit(input string tag);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge cpu_clk);
      checkOutput($sformatf("%s init%0d cmd", tag, n), 32'(cmd), 32'((n == 1) ? PRE : NOP));
      checkOutput($sformatf("%s init%0d ready", tag, n), 32'(cpu_ready), 32'((n == 8) ? 1 : 0));
    end
    checkOutput({tag, " init addr"}, 32'(ADDR), 32'h0);
  endtask

  initial begin
    logic ok;
    vecs[0] = '{1'b1, 15'h0012, 7'h04, 32'hDDCCBBAA, 0, 1, 8, 13, 32'h00000000};
    vecs[1] = '{1'b0, 15'h0012, 7'h04, 32'h0,        0, 0, 1, 6,  32'hDDCCBBAA};
    vecs[2] = '{1'b1, 15'h0012, 7'h7E, 32'h44332211, 0, 0, 1, 6,  32'hDDCCBBAA};
    vecs[3] = '{1'b0, 15'h0012, 7'h7C, 32'h0,        0, 0, 1, 6,  32'h22114433};
    vecs[4] = '{1'b0, 15'h0100, 7'h08, 32'h0,        1, 8, 15, 20, 32'h00000000};
    vecs[5] = '{1'b1, 15'h0100, 7'h08, 32'h0BADF00D, 0, 0, 1, 6,  32'h00000000};
    vecs[6] = '{1'b0, 15'h0012, 7'h04, 32'h0,        1, 8, 15, 20, 32'hDDCCBBAA};
    vecs[7] = '{1'b0, 15'h0100, 7'h0A, 32'h0,        1, 8, 15, 20, 32'hF00D0BAD};
    vecs[8] = '{1'b0, 15'h0012, 7'h04, 32'h0,        0, 1, 8, 13, 32'hDDCCBBAA};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge cpu_clk);
    checkResetValues("por");
    releaseAndCheckInit("por");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a row-hit write burst, at beat 2.
    waitReady(ok);
    if (ok) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = {15'h0100, 7'h20};
      cpu_wdata = 32'hCAFEBABE;
      for (int n = 1; n <= 4; n++) begin
        @(negedge cpu_clk);
        if (n == 1) begin
          cpu_req = 1'b0;
          checkOutput("mid wr_cmd", 32'(cmd), 32'(WR));
        end
      end
      checkOutput("mid beat2 col", 32'(COL), 32'h22);
      checkOutput("mid beat2 data", 32'(WR_DATA), 32'hFE);
      reset_n = 1'b0;
      #1;
      checkResetValues("mid");
      for (int n = 0; n < 3; n++) begin
        @(negedge cpu_clk);
        checkOutput($sformatf("mid hold%0d done", n), 32'(cpu_done), 32'h0);
        checkOutput($sformatf("mid hold%0d cmd", n), 32'(cmd), 32'hF);
      end
      releaseAndCheckInit("mid");
    end

    // Open row was forgotten, so this previously-hit row now needs an ACT.
    applyStimulus(vecs[8], 8);

    repeat (3) @(negedge cpu_clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ddr3_mem_sched.md
# ddr3_mem_sched

Command scheduler between the CPU-side request port and the DDR3 SDRAM model. It accepts one 4-byte read or write request at a time and keeps one row open between requests (open-page policy). It issues PRE/ACT/RD/WR on the {CS_N,RAS_N,CAS_N,WE_N} bus with the required wait gaps, and serialises 4-beat bursts on the 8-bit data lanes. It owns the controller side of the memory interface; the SDRAM model is its only downstream.

## Interface
- T_RP, 7: cycles from the PRE command cycle to the earliest next command (ACT).
- T_RCD, 7: cycles from the ACT command cycle to the earliest RD/WR.
- ROW_W, 15: row address width (ADDR).
- COL_W, 7: column address width (COL).
- cpu_clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ROW_W+COL_W  {row, col}.
- cpu_wdata  in  32  write data; byte 0 = [7:0] = first beat.
- cpu_ready  out  1  scheduler can accept; a transfer occurs when cpu_req && cpu_ready.
- cpu_done  out  1  one-cycle pulse when the request completes.
- cpu_rdata  out  32  read data; valid when cpu_done pulses for a read; holds its value until the next read completes.
- CK, CK_N  out  1  forwarded clock: CK = cpu_clk, CK_N = ~cpu_clk.
- CS_N, RAS_N, CAS_N, WE_N  out  1 each  command bus.
- ADDR  out  ROW_W  row address.
- COL  out  COL_W  column address of the current beat.
- WR_DATA  out  8  write beat.
- RD_DATA  in  8  read beat.
- DQS_N  in  1  low while RD_DATA carries a read beat.

## Operation
- Command codes {CS_N,RAS_N,CAS_N,WE_N}:
  - NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010.
  - Every command is driven for exactly one cycle; NOP at all other times.
- States:
  - INIT_PRE: drive PRE, go to INIT_WAIT.
  - INIT_WAIT: wait T_RP-1 cycles, go to IDLE.
  - IDLE: cpu_ready=1. On accept, latch we/addr/wdata and go to:
    - ISSUE on a row hit (row_open && row == open_row);
    - PRE_CMD on a row miss with a row open;
    - ACT_CMD when no row is open.
  - PRE_CMD: drive PRE, clear row_open, go to PRE_WAIT.
  - PRE_WAIT: wait T_RP-1 cycles, go to ACT_CMD.
  - ACT_CMD: drive ACT with ADDR=row, set row_open and open_row, go to ACT_WAIT.
  - ACT_WAIT: wait T_RCD-1 cycles, go to ISSUE.
  - ISSUE: drive RD or WR, then go to WBURST or RBURST.
  - WBURST: 4 cycles, beat k=0..3.
  - RBURST: capture beats, then go to DONE.
  - DONE: pulse cpu_done, return to IDLE.
- ADDR holds open_row from ACT_CMD until the next PRE_CMD. It is 0 from reset until the first ACT.
- Beat column: COL = {col[COL_W-1:2], col[1:0]+k}. The burst wraps within its 4-aligned group and never crosses into the next group.
- Write beats: cycle k of WBURST drives WR_DATA = cpu_wdata byte k and the beat COL. WR_DATA is 0 outside WBURST.
- Read capture:
  - In RBURST, every cycle with DQS_N==0 stores RD_DATA into byte k, then k increments.
  - After the 4th captured beat, go to DONE; cpu_rdata updates in that same edge.
- Back-to-back requests: cpu_ready is 0 in every state except IDLE, so requests are separated by at least the DONE+IDLE cycles.

## Timing
- Reset values (asserted asynchronously, held while reset_n=0):
  - CS_N/RAS_N/CAS_N/WE_N = 1111;
  - ADDR=0, COL=0, WR_DATA=0;
  - cpu_ready=0, cpu_done=0, cpu_rdata=0;
  - row_open=0, state INIT_PRE.
- Reset release: PRE in the first cycle after reset_n rises; cpu_ready=1 T_RP cycles later.
- Row-hit write, accepted in IDLE cycle T:
  - WR at T+1;
  - beats at T+2..T+5;
  - cpu_done at T+6.
- Row-hit read, accepted at T:
  - RD at T+1;
  - DQS_N low at T+2..T+5;
  - cpu_done and cpu_rdata at T+6.
- Closed row: ACT at T+1, RD/WR at T+1+T_RCD. All later timing shifts by T_RCD.
- Row miss: PRE at T+1, ACT at T+1+T_RP, RD/WR at T+1+T_RP+T_RCD.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight request is dropped; cpu_done is not pulsed for it.
  - The open row is forgotten, and re-init begins with PRE.

## Test plan
- Reset, then release -> PRE (0010) on the first cycle; NOP otherwise; cpu_ready rises 7 cycles after PRE.
- Write addr {row 0x0012, col 0x04}, wdata 0xDDCCBBAA, cold -> ACT with ADDR=0x0012; WR 7 cycles later; beats COL 0x04..0x07 carry 0xAA, 0xBB, 0xCC, 0xDD; cpu_done one cycle after the last beat.
- Read the same address (row hit) -> no ACT; RD the cycle after accept; cpu_rdata=0xDDCCBBAA with cpu_done 6 cycles after accept.
- Write col 0x7E, wdata 0x44332211 -> COL sequence 0x7E, 0x7F, 0x7C, 0x7D; read of col 0x7C returns 0x22114433.
- Read row 0x0100 while row 0x0012 is open -> PRE, ACT(0x0100) 7 cycles later, RD 7 cycles after that; total latency 20 cycles to cpu_done.
- Assert reset_n=0 during WBURST beat 2 -> outputs at reset values within the same cycle; no cpu_done; PRE re-issued after release.
